// File: rtl/wave_capture.sv
// Trigger-armed capture buffer: records DEPTH signed samples around a trigger
// event (external edge or level crossing) and reads them back oldest-first.
module wave_capture #(
   parameter int DW = 16,
   parameter int AW = 10
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [DW-1:0] din,
   input  logic          trig_in,
   input  logic          trig_sel,
   input  logic [DW-1:0] level,
   input  logic [AW-1:0] pre_len,
   input  logic          arm,
   input  logic          abort,
   output logic          busy,
   output logic          done,
   input  logic          rd_en,
   input  logic [AW-1:0] rd_addr,
   output logic [DW-1:0] rd_data,
   output logic          rd_valid
);

   // state     | meaning
   // S_IDLE    | waiting for arm
   // S_PRE     | filling pl pre-trigger samples, triggers ignored
   // S_WAIT    | circular recording, looking for trigger event
   // S_POST    | recording the remainder of the record after the trigger
   // S_DONE    | record complete, readout allowed
   typedef enum logic [2:0] {S_IDLE, S_PRE, S_WAIT, S_POST, S_DONE} state_t;

   localparam int            DEPTH = 2**AW;
   localparam logic [AW-1:0] ONE   = AW'(1);

   state_t        state, state_nx;
   logic [AW-1:0] wr_ptr, start_addr, cnt, pl;
   logic          trig_prev;
   logic [DW-1:0] din_prev;
   logic          we, load, set_start, rd_acc, trig_event;
   logic          rd_seen;
   logic [DW-1:0] rd_q;
   logic [DW-1:0] mem [DEPTH];

   assign trig_event = trig_sel ? (($signed(din_prev) < $signed(level)) && ($signed(din) >= $signed(level)))
                                : (trig_in & ~trig_prev);
   assign rd_acc     = rd_en && (state == S_DONE);

   always_comb begin
      state_nx  = state;
      we        = 1'b0;
      load      = 1'b0;
      set_start = 1'b0;
      if (abort) begin
         state_nx = S_IDLE;
      end else begin
         case (state)
            S_IDLE: if (arm) begin
               state_nx = S_PRE;
               load     = 1'b1;
            end
            S_PRE: begin
               if (cnt == pl) state_nx = S_WAIT;
               else           we       = 1'b1;
            end
            S_WAIT: begin
               we = 1'b1;
               if (trig_event) begin
                  set_start = 1'b1;
                  // with a full pre-trigger record the trigger sample is the last write
                  state_nx  = (pl == '1) ? S_DONE : S_POST;
               end
            end
            S_POST: begin
               we = 1'b1;
               if (wr_ptr == start_addr - ONE) state_nx = S_DONE;
            end
            S_DONE: if (arm) begin
               state_nx = S_PRE;
               load     = 1'b1;
            end
            default: state_nx = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= S_IDLE;
         wr_ptr     <= '0;
         start_addr <= '0;
         cnt        <= '0;
         pl         <= '0;
         trig_prev  <= 1'b0;
         din_prev   <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         rd_valid   <= 1'b0;
         rd_seen    <= 1'b0;
      end else begin
         state     <= state_nx;
         trig_prev <= trig_in;
         din_prev  <= din;
         if (load) begin
            // pre_len is AW bits wide, so it can never exceed DEPTH-1
            pl  <= pre_len;
            cnt <= '0;
         end else if (we && state == S_PRE) begin
            cnt <= cnt + ONE;
         end
         if (we)        wr_ptr     <= wr_ptr + ONE;
         if (set_start) start_addr <= wr_ptr - pl;
         busy     <= (state_nx == S_PRE) || (state_nx == S_WAIT) || (state_nx == S_POST);
         done     <= (state_nx == S_DONE);
         rd_valid <= rd_acc;
         if (rd_acc) rd_seen <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (we)     mem[wr_ptr] <= din;
      if (rd_acc) rd_q        <= mem[start_addr + rd_addr];
   end

   // RAM output has no reset; present zero until the first read lands
   assign rd_data = rd_seen ? rd_q : '0;

endmodule
